// File: rtl/config_loader_pkg.sv
// config_loader_pkg
// Shared definitions for the configuration loader: the sequencer state
// encoding, the default header magic, the header field positions and the
// default stream word width.
package config_loader_pkg;

    // Default width of stream, address and data words.
    localparam int STREAM_W = 32;

    // Header value that marks a valid configuration stream.
    localparam logic [15:0] MAGIC_DEFAULT = 16'hC0F1;

    // The magic sits in the upper half of the header word and the entry
    // count starts at bit 0.
    localparam int HDR_MAGIC_MSB = 31;
    localparam int HDR_MAGIC_LSB = 16;
    localparam int HDR_CNT_LSB   = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        ADDR  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CHECK = 3'd5,
        DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/config_checksum.sv
// config_checksum
// Running XOR accumulator over the stream words of one load.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset, clears the sum
//   clear  in   clears the sum at the start of a load
//   en     in   fold word into the sum this cycle
//   word   in   word to accumulate
//   sum    out  current accumulated XOR
module config_checksum
    import config_loader_pkg::*;
#(
    parameter int WORD_W = STREAM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [WORD_W-1:0] word,
    output logic [WORD_W-1:0] sum
);

    logic [WORD_W-1:0] sum_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum_reg <= '0;
        end else if (en) begin
            sum_reg <= sum_reg ^ word;
        end
    end

    assign sum = sum_reg;

endmodule

// File: rtl/config_loader.sv
// config_loader
// Configuration sequencer for the PE tile array. Reads a header word and
// then address/data pairs from a valid/ready word stream, and broadcasts
// each pair on config_addr/config_data with a one-cycle config_en strobe.
//
// Optional feature: define CONFIG_LOADER_CHECKSUM_EN to append a trailing
// checksum word (XOR of every address and data word) that is verified in
// the CHECK state; a mismatch sets error.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset, aborts any load
//   start        in   begin a load (only honoured in IDLE)
//   in_data      in   stream word
//   in_valid     in   in_data is valid
//   in_ready     out  word accepted this cycle (HDR/ADDR/DATA/CHECK)
//   config_addr  out  {tile_id, config_id} of the last written entry
//   config_data  out  payload of the last written entry
//   config_en    out  one-cycle write strobe
//   busy         out  high whenever not IDLE
//   done         out  one-cycle pulse at the end of a load
//   error        out  sticky error flag, cleared by an accepted start
module config_loader
    import config_loader_pkg::*;
#(
    parameter int          WORD_W = STREAM_W,
    parameter int          CNT_W  = 16,
    parameter logic [15:0] MAGIC  = MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] config_addr,
    output logic [WORD_W-1:0] config_data,
    output logic              config_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t            state_reg;
    logic [CNT_W-1:0]  remaining_reg;
    logic [WORD_W-1:0] addr_hold_reg;
    // config_data_reg doubles as the data holding register: it is only
    // loaded on the DATA transfer, i.e. exactly on entry to WRITE.
    logic [WORD_W-1:0] config_addr_reg;
    logic [WORD_W-1:0] config_data_reg;
    logic              error_reg;
    logic              xfer;

    assign xfer = in_valid && in_ready;

`ifdef CONFIG_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHECK;

    logic [WORD_W-1:0] csum;

    config_checksum #(
        .WORD_W (WORD_W)
    ) u_checksum (
        .clk   (clk),
        .reset (reset),
        .clear (state_reg == IDLE && start),
        .en    (xfer && (state_reg == ADDR || state_reg == DATA)),
        .word  (in_data),
        .sum   (csum)
    );
`else
    localparam state_t END_STATE = DONE;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            remaining_reg   <= '0;
            addr_hold_reg   <= '0;
            config_addr_reg <= '0;
            config_data_reg <= '0;
            error_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        error_reg <= 1'b0;
                        state_reg <= HDR;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        if (in_data[HDR_MAGIC_MSB:HDR_MAGIC_LSB] != MAGIC) begin
                            error_reg <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            remaining_reg <= in_data[HDR_CNT_LSB +: CNT_W];
                            if (in_data[HDR_CNT_LSB +: CNT_W] == '0) begin
                                state_reg <= END_STATE;
                            end else begin
                                state_reg <= ADDR;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (xfer) begin
                        addr_hold_reg <= in_data;
                        state_reg     <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        config_addr_reg <= addr_hold_reg;
                        config_data_reg <= in_data;
                        state_reg       <= WRITE;
                    end
                end
                WRITE: begin
                    remaining_reg <= remaining_reg - CNT_W'(1);
                    if (remaining_reg == CNT_W'(1)) begin
                        state_reg <= END_STATE;
                    end else begin
                        state_reg <= ADDR;
                    end
                end
                CHECK: begin
                    if (xfer) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                        if (in_data != csum) begin
                            error_reg <= 1'b1;
                        end
`endif
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // All handshake and status outputs are decodes of the state register,
    // so none of them depends combinationally on in_valid or start.
    assign in_ready    = (state_reg == HDR) || (state_reg == ADDR) ||
                         (state_reg == DATA) || (state_reg == CHECK);
    assign config_en   = (state_reg == WRITE);
    assign busy        = (state_reg != IDLE);
    assign done        = (state_reg == DONE);
    assign error       = error_reg;
    assign config_addr = config_addr_reg;
    assign config_data = config_data_reg;

endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader
// Scoreboard bench for config_loader: stimulus pushes the expected strobe
// pairs and end-of-load error flags into queues, and a monitor process
// pops and compares them whenever config_en or done is seen.
module tb_config_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_en;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t  exp_wr[$];
    logic exp_done[$];
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;
    logic [31:0] a_tab[4];
    logic [31:0] d_tab[4];

    config_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .config_addr (config_addr),
        .config_data (config_data),
        .config_en   (config_en),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    // Monitor: strobes and done pulses are compared against the queues;
    // between strobes the config bus must hold the last written pair.
    always @(negedge clk) begin
        if (reset) begin
            last_addr <= '0;
            last_data <= '0;
        end else begin
            if (config_en) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("strobe_addr", config_addr, e.addr);
                    chk("strobe_data", config_data, e.data);
                    last_addr <= e.addr;
                    last_data <= e.data;
                end
            end else if (config_addr !== last_addr || config_data !== last_data) begin
                chk("bus_hold_addr", config_addr, last_addr);
                chk("bus_hold_data", config_data, last_data);
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic e_err;
                    e_err = exp_done.pop_front();
                    chk("done_error", {31'd0, error}, {31'd0, e_err});
                end
            end
        end
    end

    // Present a word (optionally after a one-cycle valid gap) and return at
    // the falling edge right after it was transferred. in_valid stays high.
    task automatic send_word(input logic [31:0] w, input bit bp);
        int n;
        if (bp) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_data  = w;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("ready_timeout", 32'd1, 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("error_cleared", {31'd0, error}, 32'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("done_timeout", 32'd1, 32'd0);
        end
        @(negedge clk);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("strobes_drained", exp_wr.size(), 32'd0);
    endtask

    task automatic run_load(input logic [31:0] hdr, input int n, input bit bp, input bit flip);
        logic [15:0] magic;
        logic [31:0] csum;
        bit          bad;
        magic = hdr[31:16];
        bad   = (magic != 16'hC0F1);
        csum  = '0;
        do_start();
`ifdef CONFIG_LOADER_CHECKSUM_EN
        exp_done.push_back(bad ? 1'b1 : flip);
`else
        exp_done.push_back(bad);
`endif
        send_word(hdr, bp);
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                exp_wr.push_back({a_tab[i], d_tab[i]});
                csum = csum ^ a_tab[i] ^ d_tab[i];
                send_word(a_tab[i], bp);
                send_word(d_tab[i], bp);
                chk("strobe_after_data", {31'd0, config_en}, 32'd1);
            end
`ifdef CONFIG_LOADER_CHECKSUM_EN
            send_word(flip ? (csum ^ 32'd1) : csum, bp);
`endif
        end
        in_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_en", {31'd0, config_en}, 32'd0);
        chk("rst_addr", config_addr, 32'd0);

        // Single entry, valid held high.
        a_tab[0] = 32'h0001_0001; d_tab[0] = 32'h0000_00A5;
        run_load(32'hC0F1_0001, 1, 1'b0, 1'b0);

        // Zero entries.
        run_load(32'hC0F1_0000, 0, 1'b0, 1'b0);

        // Three entries under backpressure.
        a_tab[0] = 32'h0002_0010; d_tab[0] = 32'h1234_5678;
        a_tab[1] = 32'h0003_0020; d_tab[1] = 32'hCAFE_F00D;
        a_tab[2] = 32'h00FF_0030; d_tab[2] = 32'h0000_0001;
        run_load(32'hC0F1_0003, 3, 1'b1, 1'b0);

        // Bad magic: error is sticky until the next accepted start.
        run_load(32'hDEAD_0002, 2, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("error_sticky", {31'd0, error}, 32'd1);
        run_load(32'hC0F1_0000, 0, 1'b0, 1'b0);

        // Two entries; with the checksum build also a corrupted trailer.
        a_tab[0] = 32'h0004_0001; d_tab[0] = 32'hA5A5_0000;
        a_tab[1] = 32'h0005_0002; d_tab[1] = 32'h0000_5A5A;
        run_load(32'hC0F1_0002, 2, 1'b0, 1'b0);
        run_load(32'hC0F1_0002, 2, 1'b0, 1'b1);

        // Start while busy is ignored; reset in DATA of entry 2 aborts.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_wr.push_back({32'h0006_0001, 32'h0000_0011});
        send_word(32'hC0F1_0003, 1'b0);
        send_word(32'h0006_0001, 1'b0);
        send_word(32'h0000_0011, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_busy", {31'd0, busy}, 32'd1);
        send_word(32'h0007_0002, 1'b0);
        in_valid = 1'b0;
        chk("in_data_state", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_addr", config_addr, 32'd0);
        chk("abort_data", config_data, 32'd0);
        chk("abort_en", {31'd0, config_en}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        chk("abort_strobes", exp_wr.size(), 32'd0);
        chk("abort_no_done", exp_done.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
